// File: rtl/mips_multicycle_control.sv
// Multi-cycle main control unit for a shared-memory, shared-ALU MIPS datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback and
// bounds every memory access with a wait counter (MEM_TIMEOUT, 0 = unbounded).
// Optional build macro: MC_CTRL_TRAP_EN -- unknown opcodes park the FSM in TRAP
// and expose a 'trap' output; without it unknown opcodes retire as NOPs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for run, all outputs low
// FETCH    | read instruction at PC, PC <= PC + 4 on mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// EXEC_R   | R-type ALU operation (funct decoded downstream)
// EXEC_I   | immediate ALU operation (ori / addiu / lui)
// WB_ALU   | write ALUOut to register file, retire
// MEM_ADDR | load/store effective address
// MEM_RD   | data read, wait for mem_ready
// MEM_WR   | data write, retire on mem_ready
// WB_MEM   | write MDR to register file, retire
// BRANCH   | beq compare, PC <= ALUOut when zero, retire
// JUMP     | PC <= jump target, retire
// TRAP     | unknown opcode, held until reset (MC_CTRL_TRAP_EN only)
module mips_multicycle_control #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_zero,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                mem_err,
  output logic                busy
`ifdef MC_CTRL_TRAP_EN
  ,
  output logic                trap
`endif
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_ADDIU = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'b001111);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(3'b100);

  localparam int              CNT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MEM_TIMEOUT);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR,
    MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, TRAP
  } state_t;

  state_t           state, state_next, retire_state;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             mem_state, timeout;
  logic             zero_unused;

  // zero only qualifies pc_write_cond inside the datapath
  assign zero_unused  = zero;
  assign retire_state = run ? FETCH : IDLE;
  assign mem_state    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeout      = TIMEOUT_EN && mem_state && !mem_ready && (wait_cnt == CNT_MAX);

  // State register and memory wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Wait counter: cleared whenever the access ends or a state is (re)entered
  always_comb begin
    wait_cnt_next = '0;
    if (mem_state && !mem_ready && !timeout)
      wait_cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
  end

  // Next-state and output decode
  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_op        = ALU_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    mem_err       = timeout;
    busy          = (state != IDLE);
`ifdef MC_CTRL_TRAP_EN
    trap          = 1'b0;
`endif
    case (state)
      IDLE: if (run) state_next = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                state_next = EXEC_R;
          OP_LW, OP_SW:            state_next = MEM_ADDR;
          OP_BEQ:                  state_next = BRANCH;
          OP_J:                    state_next = JUMP;
          OP_ORI, OP_ADDIU, OP_LUI: state_next = EXEC_I;
          default: begin
`ifdef MC_CTRL_TRAP_EN
            state_next = TRAP;
`else
            instr_done = 1'b1;
            state_next = retire_state;
`endif
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        state_next = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ORI) begin
          alu_op   = ALU_OR;
          ext_zero = 1'b1;
        end else if (opcode == OP_LUI) begin
          alu_op = ALU_LUI;
        end
        state_next = WB_ALU;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        instr_done = 1'b1;
        state_next = retire_state;
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)    state_next = WB_MEM;
        else if (timeout) state_next = FETCH;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = retire_state;
        end else if (timeout) begin
          state_next = FETCH;
        end
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = retire_state;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_next    = retire_state;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_next = retire_state;
      end
      TRAP: begin
`ifdef MC_CTRL_TRAP_EN
        trap = 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Testbench for mips_multicycle_control: instruction-level timeline model.
// Each planned instruction expands into the per-cycle control words it must
// produce; stimulus (run, mem_ready, opcode, zero) is randomized where the
// control unit is expected to ignore it.
module tb_mips_multicycle_control;

  localparam int MEM_TO = 4;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0f;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, mem_err, busy;
  } ctl_t;

  typedef struct {
    logic       run;
    logic       rdy;
    logic [5:0] op;
    ctl_t       exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst, run, zero, mem_ready;
  logic [5:0] opcode;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b;
  logic alu_src_a, ext_zero, reg_dst, mem_to_reg, reg_write, instr_done, mem_err, busy;
  logic [2:0] alu_op;
`ifdef MC_CTRL_TRAP_EN
  logic trap;
`endif
  ctl_t obs;
  cyc_t plan[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, ext_zero, alu_op, reg_dst, mem_to_reg, reg_write,
                instr_done, mem_err, busy};

  mips_multicycle_control #(.OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .mem_err(mem_err), .busy(busy)
`ifdef MC_CTRL_TRAP_EN
    , .trap(trap)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic bit known(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI, OP_ADDIU, OP_LUI};
  endfunction

  function automatic ctl_t busy_only();
    ctl_t c = '0;
    c.busy = 1'b1;
    return c;
  endfunction

  function automatic void push(input logic r, input logic rdy, input logic [5:0] op, input ctl_t e);
    cyc_t c;
    c.run = r; c.rdy = rdy; c.op = op; c.exp = e;
    plan.push_back(c);
  endfunction

  function automatic void push_idle(input logic r);
    push(r, rnd_bit(), rnd_op(), '0);
  endfunction

  // kind 0 = instruction fetch, 1 = data read, 2 = data write.
  // waits = cycles of mem_ready low before it rises; returns 1 if the access completes.
  function automatic bit plan_mem(input int kind, input int waits, input logic [5:0] op,
                                  input logic run_done);
    ctl_t c;
    for (int k = 0; k <= MEM_TO; k++) begin
      c = busy_only();
      c.mem_req = 1'b1;
      if (kind == 0) c.alu_src_b = 2'b01;
      else begin
        c.i_or_d = 1'b1;
        c.mem_we = (kind == 2);
      end
      if (k == waits) begin
        if (kind == 0) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
        if (kind == 2) c.instr_done = 1'b1;
        push((kind == 2) ? run_done : rnd_bit(), 1'b1, (kind == 0) ? rnd_op() : op, c);
        return 1'b1;
      end
      if (k == MEM_TO) begin
        c.mem_err = 1'b1;
        push(rnd_bit(), 1'b0, (kind == 0) ? rnd_op() : op, c);
        return 1'b0;
      end
      push(rnd_bit(), 1'b0, (kind == 0) ? rnd_op() : op, c);
    end
    return 1'b0;
  endfunction

  // Expands one instruction; returns 1 if it retires (instr_done seen).
  function automatic bit plan_instr(input logic [5:0] op, input int wf, input int wm,
                                    input logic run_done);
    ctl_t c;
    if (!plan_mem(0, wf, op, 1'b0)) return 1'b0;
    c = busy_only();
    c.alu_src_b = 2'b11;
    if (!known(op)) begin
`ifdef MC_CTRL_TRAP_EN
      push(rnd_bit(), rnd_bit(), op, c);
      return 1'b0;
`else
      c.instr_done = 1'b1;
      push(run_done, rnd_bit(), op, c);
      return 1'b1;
`endif
    end
    push(rnd_bit(), rnd_bit(), op, c);
    c = busy_only();
    if (op == OP_LW || op == OP_SW) begin
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      push(rnd_bit(), rnd_bit(), op, c);
      if (!plan_mem((op == OP_LW) ? 1 : 2, wm, op, run_done)) return 1'b0;
      if (op == OP_LW) begin
        c = busy_only();
        c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
        push(run_done, rnd_bit(), op, c);
      end
      return 1'b1;
    end
    if (op == OP_BEQ) begin
      c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_write_cond = 1'b1;
      c.pc_source = 2'b01; c.instr_done = 1'b1;
      push(run_done, rnd_bit(), op, c);
      return 1'b1;
    end
    if (op == OP_J) begin
      c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
      push(run_done, rnd_bit(), op, c);
      return 1'b1;
    end
    c.alu_src_a = 1'b1;
    if (op == OP_R) c.alu_op = 3'b010;
    else begin
      c.alu_src_b = 2'b10;
      if (op == OP_ORI) begin c.alu_op = 3'b011; c.ext_zero = 1'b1; end
      if (op == OP_LUI) c.alu_op = 3'b100;
    end
    push(rnd_bit(), rnd_bit(), op, c);
    c = busy_only();
    c.reg_write = 1'b1; c.reg_dst = (op == OP_R); c.instr_done = 1'b1;
    push(run_done, rnd_bit(), op, c);
    return 1'b1;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI, OP_ADDIU, OP_LUI};
    logic [5:0] u;
`ifndef MC_CTRL_TRAP_EN
    if ($urandom_range(0, 8) == 0) begin
      do u = rnd_op(); while (known(u));
      return u;
    end
`endif
    return ops[$urandom_range(0, 7)];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = OP_R; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (obs !== '0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, obs);
      end
    end
    @(negedge clk); rst = 1'b0; run = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL idle_no_run got=%h exp=0", obs);
    end
  endtask

  task automatic test_r_type();
    int done_cnt = 0;
    plan.delete();
    push_idle(1'b1);
    void'(plan_instr(OP_R, 0, 0, 1'b0));
    push_idle(1'b0);
    foreach (plan[i]) begin
      @(negedge clk);
      run = plan[i].run; mem_ready = plan[i].rdy; opcode = plan[i].op; zero = rnd_bit();
      #1;
      if (instr_done === 1'b1) done_cnt++;
      checks++;
      if (obs !== plan[i].exp) begin
        failures++;
        $display("FAIL r_type cyc=%0d got=%h exp=%h", i, obs, plan[i].exp);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL r_type_done_pulses got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_lw_wait();
    int busy_cnt = 0;
    int rd_cnt = 0;
    plan.delete();
    push_idle(1'b1);
    void'(plan_instr(OP_LW, 0, 3, 1'b0));
    push_idle(1'b0);
    foreach (plan[i]) begin
      @(negedge clk);
      run = plan[i].run; mem_ready = plan[i].rdy; opcode = plan[i].op; zero = rnd_bit();
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (mem_req === 1'b1 && i_or_d === 1'b1) rd_cnt++;
      checks++;
      if (obs !== plan[i].exp) begin
        failures++;
        $display("FAIL lw_wait cyc=%0d got=%h exp=%h", i, obs, plan[i].exp);
      end
    end
    checks++;
    if (busy_cnt != 8 || rd_cnt != 4) begin
      failures++;
      $display("FAIL lw_cycles got busy=%0d rd=%0d exp busy=8 rd=4", busy_cnt, rd_cnt);
    end
  endtask

  task automatic test_fetch_timeout();
    int err_cnt = 0;
    plan.delete();
    push_idle(1'b1);
    void'(plan_instr(OP_J, MEM_TO + 1, 0, 1'b1));   // fetch abandoned on 5th cycle
    void'(plan_instr(OP_J, MEM_TO, 0, 1'b1));       // ready exactly at the limit wins
    void'(plan_instr(OP_LW, 0, MEM_TO + 1, 1'b1));  // data read abandoned
    void'(plan_instr(OP_SW, 0, MEM_TO + 1, 1'b1));  // data write abandoned
    void'(plan_instr(OP_SW, 0, MEM_TO, 1'b0));
    push_idle(1'b0);
    foreach (plan[i]) begin
      @(negedge clk);
      run = plan[i].run; mem_ready = plan[i].rdy; opcode = plan[i].op; zero = rnd_bit();
      #1;
      if (mem_err === 1'b1) err_cnt++;
      checks++;
      if (obs !== plan[i].exp) begin
        failures++;
        $display("FAIL mem_timeout cyc=%0d got=%h exp=%h", i, obs, plan[i].exp);
      end
    end
    checks++;
    if (err_cnt != 3) begin
      failures++;
      $display("FAIL mem_err_pulses got=%0d exp=3", err_cnt);
    end
  endtask

  task automatic test_branch_ori();
    plan.delete();
    push_idle(1'b1);
    void'(plan_instr(OP_BEQ, 1, 0, 1'b1));
    void'(plan_instr(OP_ORI, 0, 0, 1'b1));
    void'(plan_instr(OP_ADDIU, 2, 0, 1'b1));
    void'(plan_instr(OP_LUI, 0, 0, 1'b0));
    push_idle(1'b0);
    foreach (plan[i]) begin
      @(negedge clk);
      run = plan[i].run; mem_ready = plan[i].rdy; opcode = plan[i].op; zero = rnd_bit();
      #1;
      checks++;
      if (obs !== plan[i].exp) begin
        failures++;
        $display("FAIL branch_imm cyc=%0d got=%h exp=%h", i, obs, plan[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    plan.delete();
    push_idle(1'b1);
    void'(plan_instr(OP_SW, 0, MEM_TO, 1'b0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = plan[i].run; mem_ready = plan[i].rdy; opcode = plan[i].op; zero = rnd_bit();
      #1;
      checks++;
      if (obs !== plan[i].exp) begin
        failures++;
        $display("FAIL rst_mid_wr_pre cyc=%0d got=%h exp=%h", i, obs, plan[i].exp);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rst_async got=%b exp=000 (mem_req,mem_we,busy)", {mem_req, mem_we, busy});
    end
    @(negedge clk); rst = 1'b0; run = 1'b0; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL rst_mid_wr_idle got=%h exp=0", obs);
    end
  endtask

  task automatic test_unknown_op();
    int done_cnt = 0;
    plan.delete();
    push_idle(1'b1);
`ifdef MC_CTRL_TRAP_EN
    void'(plan_instr(6'h3f, 0, 0, 1'b1));
`else
    void'(plan_instr(6'h3f, 0, 0, 1'b1));
    void'(plan_instr(6'h3e, 1, 0, 1'b0));
    push_idle(1'b0);
`endif
    foreach (plan[i]) begin
      @(negedge clk);
      run = plan[i].run; mem_ready = plan[i].rdy; opcode = plan[i].op; zero = rnd_bit();
      #1;
      if (instr_done === 1'b1) done_cnt++;
      checks++;
      if (obs !== plan[i].exp) begin
        failures++;
        $display("FAIL unknown_op cyc=%0d got=%h exp=%h", i, obs, plan[i].exp);
      end
    end
`ifdef MC_CTRL_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run = rnd_bit(); mem_ready = rnd_bit(); opcode = rnd_op();
      #1;
      if (instr_done === 1'b1) done_cnt++;
      checks++;
      if ({trap, busy, mem_req} !== 3'b110) begin
        failures++;
        $display("FAIL trap_hold cyc=%0d got=%b exp=110 (trap,busy,mem_req)", i, {trap, busy, mem_req});
      end
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL trap_done_pulses got=%0d exp=0", done_cnt);
    end
    @(negedge clk); rst = 1'b1; run = 1'b0;
    #1;
    checks++;
    if ({trap, busy} !== 2'b00) begin
      failures++;
      $display("FAIL trap_reset got=%b exp=00", {trap, busy});
    end
    @(negedge clk); rst = 1'b0;
`else
    checks++;
    if (done_cnt != 2) begin
      failures++;
      $display("FAIL nop_done_pulses got=%0d exp=2", done_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    logic       rd;
    bit         ok;
    plan.delete();
    push_idle(1'b1);
    for (int n = 0; n < 40; n++) begin
      op = pick_op();
      rd = (n == 39) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      do ok = plan_instr(op, $urandom_range(0, MEM_TO + 1), $urandom_range(0, MEM_TO + 1), rd);
      while (!ok);
      if (!rd) begin
        push_idle(1'b0);
        if (n != 39) push_idle(1'b1);
      end
    end
    foreach (plan[i]) begin
      @(negedge clk);
      run = plan[i].run; mem_ready = plan[i].rdy; opcode = plan[i].op; zero = rnd_bit();
      #1;
      checks++;
      if (obs !== plan[i].exp) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs, plan[i].exp);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_fetch_timeout();
    test_branch_ori();
    test_reset_mid_write();
    test_unknown_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle main control unit; successor to the single-cycle opcode decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives a shared-memory, shared-ALU datapath.
- Adds a variable-latency memory handshake with a parametrised timeout, plus extra opcodes (addiu, lui).
- Sits between the instruction register (opcode in) and the datapath control muxes/enables.

Parameters:
- OPCODE_W, 6: opcode field width.
- ALUOP_W, 3: alu_op width; must be >= 3.
- MEM_TIMEOUT, 255: maximum wait cycles for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  allow a new instruction fetch when high.
- opcode  in  OPCODE_W  instruction[31:26], valid from DECODE onwards.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero.
- pc_source  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B select: 00 reg B, 01 constant 4, 10 extended imm, 11 sign-extended imm<<2.
- ext_zero  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- alu_op  out  ALUOP_W  ALU operation: 000 add, 001 sub, 010 funct, 011 or, 100 lui.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback data: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- mem_err  out  1  one-cycle pulse on memory timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- State register only; all outputs are decoded combinationally from state (and mem_ready where noted). Timeout counter width is clog2(MEM_TIMEOUT+1).
- rst asserted at any time (including mid-access) forces state to IDLE and clears the counter. In IDLE, every output is 0.
- IDLE: go to FETCH when run=1, otherwise stay.
- FETCH:
  - mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; FSM then goes to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=000 (branch target computed into ALUOut).
  - Next state by opcode: 000000 -> EXEC_R; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; 001101/001001/001111 -> EXEC_I; any other opcode -> FETCH if run, else IDLE, with instr_done=1 (treated as a NOP).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010 -> WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10. Per opcode:
  - ori: alu_op=011, ext_zero=1.
  - addiu: alu_op=000.
  - lui: alu_op=100.
  - All three -> WB_ALU.
- WB_ALU:
  - reg_write=1, mem_to_reg=0; reg_dst=1 only for R-type.
  - instr_done=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, i_or_d=1. Wait for mem_ready, then -> WB_MEM.
- MEM_WR:
  - mem_req=1, mem_we=1, i_or_d=1.
  - On mem_ready: instr_done=1.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, instr_done=1.
- JUMP: pc_write=1, pc_source=10, instr_done=1.
- Retirement: every state that asserts instr_done goes next to FETCH if run=1, otherwise to IDLE.
- Memory timeout (FETCH, MEM_RD, MEM_WR):
  - The counter clears on entry to the state and increments each cycle mem_ready=0.
  - With MEM_TIMEOUT>0, when the count reaches MEM_TIMEOUT with mem_ready still 0: mem_err=1 for that cycle, no write enables fire, and the FSM returns to FETCH. The instruction is abandoned and the PC is unchanged.
  - mem_ready=1 in the same cycle as the limit takes priority over the timeout.
- run is sampled only in IDLE and at retirement; it never aborts an instruction in flight.

Optional Feature:
- MC_CTRL_TRAP_EN defined:
  - Unknown opcodes in DECODE go to TRAP, where trap=1 (extra 1-bit output port, present only when the macro is defined).
  - TRAP is held until rst; no instr_done is issued.
- MC_CTRL_TRAP_EN undefined: unknown opcodes retire as NOPs (behaviour above), and no trap port exists.

Test Plan:
- Reset, then run=1 with mem_ready=1 every cycle, opcode=000000 -> states IDLE, FETCH, DECODE, EXEC_R, WB_ALU. reg_write=1 and reg_dst=1 in cycle 5; instr_done pulses once.
- lw (100011) with mem_ready held low for 3 cycles in MEM_RD -> mem_req stays high for 4 cycles; WB_MEM asserts mem_to_reg=1; instruction takes 8 cycles in total.
- MEM_TIMEOUT=4, FETCH with mem_ready=0 -> mem_err pulses on the 5th FETCH cycle; ir_write and pc_write are never asserted; FETCH is re-entered.
- beq (000100) -> in BRANCH: pc_write_cond=1, alu_op=001, pc_source=01; ori (001101) -> ext_zero=1 and alu_op=011 in EXEC_I.
- rst asserted mid-MEM_WR -> mem_req and mem_we drop to 0 immediately (asynchronously); FSM is in IDLE afterwards.
- opcode=111111: without the macro -> instr_done pulses in DECODE; with MC_CTRL_TRAP_EN -> trap=1 and held until rst.
